uart_rx_fifo: RTL

Mid-bit-sampling UART receiver with a small receive FIFO and sticky error flags, for 8N1 frames (8E1 when parity is compiled in). It is the receive end of the team's UART transmitter: its `rxd` input connects to the transmitter's `txD` line. It replaces the bare `rx_data`/`rdrf` output with a valid/ready pop interface, so that consumers such as the monitor and bench can drain bytes at their own pace.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_fifo_mem.sv | 61 ++++++
 rtl/uart_rx_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_par(input logic [UART_DATA_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: synchronous FIFO; a push while full is accepted only if a pop frees a slot.
module uart_rx_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (do_pop) rd_d = rd_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: mid-bit sampling UART receiver (8N1) with receive FIFO and sticky error flags.
// Define UART_RX_PARITY_EN for 8E1 frames with a live par_err flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   rxd,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   frame_err,
  output logic                   par_err,
  output logic                   overrun,
  input  logic                   err_clr
);
  // state  | meaning
  // IDLE   | line idle, counters held at 0
  // START  | half-bit wait, then re-check the start bit
  // DATA   | sample 8 data bits, LSB first
  // PARITY | sample even parity bit (parity builds only)
  // STOP   | sample stop bit; after a low stop, wait for the line to go high

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  // The IDLE->START clock counts toward the half bit, hence the -1.
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic                   sync_q, rxs_q;
  rx_state_t              state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   brk_q, brk_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   push, pop, fe_set, ovr_set;
  logic                   fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   par_err_q, par_err_d;
  logic                   pe_set;
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    brk_d   = brk_q;
    push    = 1'b0;
    fe_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    pe_set    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        brk_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rxs_q) state_d = START;
      end
      START: begin
        if (baud_q == BAUD_HALF) begin
          baud_d  = '0;
          state_d = rxs_q ? IDLE : DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {rxs_q, shift_q[UART_DATA_W-1:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = STOP;
          if (rxs_q != even_par(shift_q)) begin
            par_bad_d = 1'b1;
            pe_set    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        if (brk_q) begin
          if (rxs_q) state_d = IDLE;
        end else if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
            push = ~par_bad_q;
`else
            push = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            fe_set = 1'b1;
            brk_d  = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop         = rx_valid & rx_ready;
  assign ovr_set     = push & fifo_full & ~pop;
  assign frame_err_d = (frame_err_q & ~err_clr) | fe_set;
  assign overrun_d   = (overrun_q & ~err_clr) | ovr_set;
`ifdef UART_RX_PARITY_EN
  assign par_err_d   = (par_err_q & ~err_clr) | pe_set;
  assign par_err     = par_err_q;
`else
  assign par_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q      <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      brk_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      sync_q      <= rxd;
      rxs_q       <= sync_q;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      brk_q       <= brk_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  uart_rx_fifo_mem #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_mem (
    .clk   (clk),
    .clr_n (clr_n),
    .push  (push),
    .pop   (pop),
    .din   (shift_q),
    .dout  (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid  = ~fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
